des3_mode_ctrl: RTL and testbench

Block-mode sequencer for the `des3` triple-DES core. It accepts a stream of 64-bit blocks over a valid/ready handshake and drives the core one block at a time: start pulse, wait for result, optional CBC chaining. Results are returned on a second valid/ready stream. It sits between a DMA/FIFO front end and a single `des3` instance; keys are wired to the core directly and are not handled here.

---
 rtl/des3_mode_ctrl_if.sv | 12 +
 rtl/des3_mode_ctrl.sv | 144 ++++++++++++++
 tb/tb_des3_mode_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/des3_mode_ctrl_if.sv
// Block streams for des3_mode_ctrl: input blocks (valid/ready) and result blocks (valid/ready).
interface des3_mode_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/des3_mode_ctrl.sv
// Block-mode sequencer for a des3 core: ECB always, CBC chaining when DES3_CTRL_CBC_EN is defined.
// One block in flight; results held on the output stream until consumed.
module des3_mode_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 cfg_decrypt,
  input  logic                 cfg_cbc,
  input  logic                 iv_load,
  input  logic [63:0]          iv,
  des3_mode_ctrl_if.slave      bus,
  output logic                 core_start,
  output logic                 core_decrypt,
  output logic [63:0]          core_din,
  input  logic [63:0]          core_dout,
  input  logic                 core_valid,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_OUT, S_ERR} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_cv_q;
  logic        r_dec;
  logic        r_err;
  logic [7:0]  r_cnt;
  logic [63:0] r_core_din;
  logic [63:0] r_out_data;
  logic [63:0] w_din_acc;
  logic [63:0] w_out_calc;
  logic [7:0]  w_cnt_nxt;
  logic        w_accept, w_edge, w_tmo;

  assign w_accept  = bus.in_valid & (r_state == S_IDLE);
  assign w_edge    = core_valid & ~r_cv_q;
  assign w_cnt_nxt = r_cnt + 8'd1;
  assign w_tmo     = (TO != 8'd0) && (w_cnt_nxt == TO);

`ifdef DES3_CTRL_CBC_EN
  logic        r_cbc;
  logic [63:0] r_chain;
  logic [63:0] w_r_eff;

  // An iv_load coinciding with accept must chain against the new IV.
  assign w_r_eff    = iv_load ? iv : r_chain;
  assign w_din_acc  = (cfg_cbc & ~cfg_decrypt) ? (bus.in_data ^ w_r_eff) : bus.in_data;
  assign w_out_calc = (r_cbc & r_dec) ? (core_dout ^ r_chain) : core_dout;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cbc   <= 1'b0;
      r_chain <= 64'd0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) r_cbc <= cfg_cbc;
      if (iv_load)  r_chain <= iv;
    end else if (r_state == S_WAIT && w_edge && r_cbc) begin
      // Decrypt chains on the ciphertext, which is what core_din still holds.
      r_chain <= r_dec ? r_core_din : core_dout;
    end
  end
`else
  logic w_unused;
  assign w_unused   = ^{cfg_cbc, iv_load, iv};
  assign w_din_acc  = bus.in_data;
  assign w_out_calc = core_dout;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    core_start    = 1'b0;
    busy          = 1'b1;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) w_state_nxt = S_START;
      end
      S_START: begin
        core_start  = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_edge)     w_state_nxt = S_OUT;
        else if (w_tmo) w_state_nxt = S_ERR;
      end
      S_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (err_clr) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cv_q     <= 1'b0;
      r_dec      <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= 8'd0;
      r_core_din <= 64'd0;
      r_out_data <= 64'd0;
    end else begin
      r_cv_q <= core_valid;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_dec      <= cfg_decrypt;
          r_core_din <= w_din_acc;
        end
        S_START: r_cnt <= 8'd0;
        S_WAIT: begin
          if (w_edge) begin
            r_out_data <= w_out_calc;
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_tmo) r_err <= 1'b1;
          end
        end
        S_ERR: if (err_clr) r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.out_data = r_out_data;
  assign core_din     = r_core_din;
  assign core_decrypt = r_dec;
  assign err          = r_err;

endmodule

// File: tb/tb_des3_mode_ctrl.sv
// Bench for des3_mode_ctrl: stub core with a known-vector table, table vectors, random blocks
// against a chaining reference model, backpressure, timeout and async-reset sequences.
module tb_des3_mode_ctrl;
  localparam int TO = 16;
`ifdef DES3_CTRL_CBC_EN
  localparam bit CBC_EN = 1'b1;
`else
  localparam bit CBC_EN = 1'b0;
`endif
  localparam logic [63:0] KEY = 64'hA5A5_3C3C_0F0F_9696;
  localparam logic [63:0] P0  = 64'h0123456789ABCDEF;
  localparam logic [63:0] C0  = 64'h85E813540F0AB405;
  localparam logic [63:0] P1  = 64'h84CB563386A179EA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_decrypt = 1'b0, cfg_cbc = 1'b0, iv_load = 1'b0, err_clr = 1'b0;
  logic [63:0] iv = 64'd0;
  logic        core_start, core_decrypt, busy, err;
  logic [63:0] core_din;
  logic [63:0] core_dout = 64'd0;
  logic        core_valid = 1'b0;

  int          n_cmp = 0, n_bad = 0;
  int          core_lat = 3;
  bit          core_stuck = 1'b0;
  int          cnt = 0;
  logic [63:0] core_res = 64'd0;
  logic [63:0] m_r = 64'd0;

  des3_mode_ctrl_if bus();

  des3_mode_ctrl #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cfg_decrypt(cfg_decrypt), .cfg_cbc(cfg_cbc), .iv_load(iv_load), .iv(iv),
    .bus(bus),
    .core_start(core_start), .core_decrypt(core_decrypt), .core_din(core_din),
    .core_dout(core_dout), .core_valid(core_valid),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: real DES for the FIPS vector pair, an invertible rotate/xor otherwise.
  function automatic logic [63:0] core_fn(input logic [63:0] x, input bit dec);
    logic [63:0] y;
    if (!dec) begin
      if (x == P0) return C0;
      return {x[50:0], x[63:51]} ^ KEY;
    end
    if (x == C0) return P0;
    y = x ^ KEY;
    return {y[12:0], y[63:13]};
  endfunction

  always @(posedge clk) begin
    if (core_start) begin
      core_valid <= 1'b0;
      cnt        <= core_stuck ? 0 : core_lat;
      core_res   <= core_fn(core_din, core_decrypt);
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        core_valid <= 1'b1;
        core_dout  <= core_res;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {63'd0, act}, {63'd0, exp});
  endtask

  // Mode semantics straight from the block-mode definitions, with R as a plain variable.
  task automatic model(input logic [63:0] x, input bit dec, input bit cbc, input bit ivl,
                       input logic [63:0] ivv, output logic [63:0] din, output logic [63:0] res);
    bit c;
    c = cbc && CBC_EN;
    if (CBC_EN && ivl) m_r = ivv;
    if (c && !dec) begin
      din = x ^ m_r; res = core_fn(din, 1'b0); m_r = res;
    end else if (c) begin
      din = x; res = core_fn(x, 1'b1) ^ m_r; m_r = x;
    end else begin
      din = x; res = core_fn(x, dec);
    end
  endtask

  task automatic run_block(input string nm, input logic [63:0] x, input bit dec, input bit cbc,
                           input bit ivl, input logic [63:0] ivv, input logic [63:0] exp_res,
                           input logic [63:0] exp_din, input int hold, input bit mid_iv);
    int k, starts;
    logic [63:0] din_s, held;
    logic dec_s;
    bit stable;
    k = 0;
    while (!bus.in_ready && k < 200) begin step(); k++; end
    chk1({nm, " in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.in_data = x;
    cfg_decrypt = dec; cfg_cbc = cbc; iv_load = ivl; iv = ivv;
    step();
    // Flip config after accept: it must have been latched already.
    bus.in_valid = 1'b0; iv_load = 1'b0; cfg_decrypt = ~dec; cfg_cbc = ~cbc;
    bus.in_data = {$urandom, $urandom};
    k = 1; starts = 0; din_s = '0; dec_s = 1'b0;
    while (!bus.out_valid && k < 300) begin
      if (core_start) begin starts++; din_s = core_din; dec_s = core_decrypt; end
      if (mid_iv && k == 3) begin iv_load = 1'b1; iv = {$urandom, $urandom}; end
      else iv_load = 1'b0;
      step(); k++;
    end
    iv_load = 1'b0;
    chk1({nm, " out_valid"}, bus.out_valid, 1'b1);
    chk({nm, " starts"}, 64'(starts), 64'd1);
    chk({nm, " core_din"}, din_s, exp_din);
    chk1({nm, " core_dec"}, dec_s, dec);
    chk({nm, " latency"}, 64'(k), 64'(core_lat + 3));
    chk({nm, " out_data"}, bus.out_data, exp_res);
    held = bus.out_data; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!bus.out_valid || bus.out_data !== held || bus.in_ready || core_din !== din_s) stable = 1'b0;
    end
    if (hold > 0) chk1({nm, " held"}, stable, 1'b1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk1({nm, " out_valid after"}, bus.out_valid, 1'b0);
    chk1({nm, " in_ready after"}, bus.in_ready, 1'b1);
  endtask

  typedef struct {
    logic [63:0] x;
    bit          dec, cbc, ivl;
    logic [63:0] ivv;
    logic [63:0] exp;
    int          hold;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [63:0] din, res;
    int k;
    bit ok;

    tbl[0] = '{P0, 1'b0, 1'b0, 1'b0, 64'd0, C0, 0};
    tbl[1] = '{P0, 1'b0, 1'b1, 1'b1, 64'd0, C0, 0};
    tbl[2] = '{P1, 1'b0, 1'b1, 1'b0, 64'd0, CBC_EN ? C0 : core_fn(P1, 1'b0), 0};
    tbl[3] = '{C0, 1'b1, 1'b1, 1'b1, 64'd0, P0, 0};
    tbl[4] = '{C0, 1'b1, 1'b1, 1'b0, 64'd0, CBC_EN ? P1 : P0, 0};
    tbl[5] = '{P0, 1'b0, 1'b0, 1'b0, 64'd0, C0, 20};
    tbl[6] = '{C0, 1'b1, 1'b0, 1'b0, 64'd0, P0, 0};

    bus.in_valid = 1'b0; bus.in_data = 64'd0; bus.out_ready = 1'b0;
    #22 rst_n = 1'b1;
    #1;
    chk1("rst in_ready", bus.in_ready, 1'b1);
    chk1("rst busy", busy, 1'b0);
    chk1("rst err", err, 1'b0);
    chk1("rst out_valid", bus.out_valid, 1'b0);
    chk1("rst core_start", core_start, 1'b0);
    chk("rst core_din", core_din, 64'd0);
    chk("rst out_data", bus.out_data, 64'd0);

    // err_clr outside ERR has no effect
    step(); err_clr = 1'b1; step(); err_clr = 1'b0;
    chk1("err_clr idle busy", busy, 1'b0);

    for (int i = 0; i < 7; i++) begin
      model(tbl[i].x, tbl[i].dec, tbl[i].cbc, tbl[i].ivl, tbl[i].ivv, din, res);
      run_block($sformatf("vec%0d", i), tbl[i].x, tbl[i].dec, tbl[i].cbc, tbl[i].ivl,
                tbl[i].ivv, tbl[i].exp, din, tbl[i].hold, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [63:0] x, ivv;
      bit dec, cbc, ivl, mid;
      x = {$urandom, $urandom}; ivv = {$urandom, $urandom};
      dec = 1'($urandom); cbc = 1'($urandom); ivl = ($urandom_range(0, 3) == 0);
      mid = 1'($urandom);
      core_lat = $urandom_range(2, 6);
      model(x, dec, cbc, ivl, ivv, din, res);
      run_block($sformatf("rnd%0d", i), x, dec, cbc, ivl, ivv, res, din, $urandom_range(0, 3), mid);
    end
    core_lat = 3;

    // Timeout: the core never answers, so the block is dropped and R is untouched.
    core_stuck = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = P0; cfg_decrypt = 1'b0; cfg_cbc = 1'b0;
    step();
    bus.in_valid = 1'b0;
    k = 1;
    while (!err && k < 100) begin step(); k++; end
    chk1("tmo err", err, 1'b1);
    chk("tmo cycles", 64'(k), 64'(TO + 2));
    ok = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.in_ready || bus.out_valid || !busy || !err) ok = 1'b0;
      step();
    end
    bus.in_valid = 1'b0;
    chk1("tmo err hold", ok, 1'b1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk1("tmo clr err", err, 1'b0);
    chk1("tmo clr in_ready", bus.in_ready, 1'b1);
    core_stuck = 1'b0;
    step(); step();

    // Async reset while waiting on the core.
    bus.in_valid = 1'b1; bus.in_data = P1; cfg_decrypt = 1'b1; cfg_cbc = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    chk1("ar in WAIT busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("ar in_ready", bus.in_ready, 1'b1);
    chk1("ar busy", busy, 1'b0);
    chk1("ar core_start", core_start, 1'b0);
    chk1("ar core_dec", core_decrypt, 1'b0);
    chk("ar core_din", core_din, 64'd0);
    chk1("ar out_valid", bus.out_valid, 1'b0);
    chk("ar out_data", bus.out_data, 64'd0);
    chk1("ar err", err, 1'b0);
    m_r = 64'd0;
    #10 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    model(C0, 1'b1, 1'b1, 1'b0, 64'd0, din, res);
    run_block("post_rst", C0, 1'b1, 1'b1, 1'b0, 64'd0, res, din, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
